// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit segment multiplexer.
package seg_pkg;

  typedef enum logic [1:0] {
    DIG0_ON = 2'd0,
    BLANK0  = 2'd1,
    DIG1_ON = 2'd2,
    BLANK1  = 2'd3
  } mux_state_t;

  // Segment and anode lines are active-low, so all-ones is dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/seven_seg.sv
// Hex digit to active-low seven-segment decoder; seg = {g, f, e, d, c, b, a}.
module seven_seg (
  input  logic [3:0] s,
  output logic [6:0] seg
);

  // Pure lookup, one pattern per hex value
  always_comb begin
    seg = 7'b1111111;
    unique case (s)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_mux_ctrl.sv
// Time-multiplexes one seven_seg decoder across two common-anode digits,
// with dead-time blanking between digits to suppress ghosting.
module seg_mux_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 24000,
  parameter int unsigned BLANK_CYCLES   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned MaxCycles = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES
                                                                      : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam bit          NoBlank   = (BLANK_CYCLES == 0);

  localparam logic [CntW-1:0] DigLast   = CntW'(REFRESH_CYCLES - 1);
  // BLANK1 still lasts one cycle after reset/en even when blanking is disabled.
  localparam logic [CntW-1:0] BlankLast = NoBlank ? '0 : CntW'(BLANK_CYCLES - 1);

  mux_state_t      state;
  logic [CntW-1:0] cnt;
  logic [3:0]      cur;
  logic            lit;
  logic            phase_done;
  logic [6:0]      dec_seg;

  // Phase terminates on the last count of its duration
  always_comb begin
    lit        = (state == DIG0_ON) || (state == DIG1_ON);
    phase_done = lit ? (cnt == DigLast) : (cnt == BlankLast);
  end

  // Refresh FSM, phase counter and per-phase digit capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK1;
      cnt   <= '0;
      cur   <= 4'h0;
    end else if (!en) begin
      state <= BLANK1;
      cnt   <= '0;
    end else if (phase_done) begin
      cnt <= '0;
      unique case (state)
        DIG0_ON: begin
          if (NoBlank) begin
            state <= DIG1_ON;
            cur   <= s1;
          end else begin
            state <= BLANK0;
          end
        end
        BLANK0: begin
          state <= DIG1_ON;
          cur   <= s1;
        end
        DIG1_ON: begin
          if (NoBlank) begin
            state <= DIG0_ON;
            cur   <= s0;
          end else begin
            state <= BLANK1;
          end
        end
        BLANK1: begin
          state <= DIG0_ON;
          cur   <= s0;
        end
      endcase
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  seven_seg u_seven_seg (
    .s   (cur),
    .seg (dec_seg)
  );

  // Moore outputs: one anode per lit state, decoder gated off while blanking
  always_comb begin
    seg = lit ? dec_seg : SEG_OFF;
    an  = AN_OFF;
    unique case (state)
      DIG0_ON: an = 2'b10;
      DIG1_ON: an = 2'b01;
      BLANK0:  an = AN_OFF;
      BLANK1:  an = AN_OFF;
    endcase
  end

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Self-checking bench: one DUT with blanking (R=4, B=2), one without (R=4, B=0).
module tb_seg_mux_ctrl;

  localparam int unsigned R = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;

  int n_tests = 0;
  int n_fail  = 0;

  seg_mux_ctrl #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .s0    (s0),
    .s1    (s1),
    .seg   (seg_a),
    .an    (an_a)
  );

  seg_mux_ctrl #(.REFRESH_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .s0    (s0),
    .s1    (s1),
    .seg   (seg_b),
    .an    (an_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'ha: r = 7'h08;  4'hb: r = 7'h03;
      4'hc: r = 7'h46;  4'hd: r = 7'h21;  4'he: r = 7'h06;  default: r = 7'h0e;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: dark countdown after reset/en-low, then a free-running
  // position within the 2*(R+B) period measured from the start of digit 0.
  int         blank_of [2] = '{2, 0};
  int         m_start  [2];
  int         m_pos    [2];
  logic [3:0] m_cur    [2];

  typedef struct {
    logic [1:0] an_a;
    logic [6:0] seg_a;
    logic [1:0] an_b;
    logic [6:0] seg_b;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int b;
      int p;
      b = blank_of[k];
      p = 2 * (R + b);
      if (reset || !en) begin
        m_start[k] = (b == 0) ? 1 : b;
        if (reset) m_cur[k] = 4'h0;
      end else if (m_start[k] > 0) begin
        m_start[k]--;
        if (m_start[k] == 0) begin
          m_pos[k] = 0;
          m_cur[k] = s0;
        end
      end else begin
        m_pos[k] = (m_pos[k] + 1) % p;
        if (m_pos[k] == 0) m_cur[k] = s0;
        else if (m_pos[k] == R + b) m_cur[k] = s1;
      end
    end
  endtask

  task automatic model_out(input int k, output logic [1:0] an, output logic [6:0] seg);
    int b;
    b   = blank_of[k];
    an  = 2'b11;
    seg = 7'h7f;
    if (m_start[k] == 0) begin
      if (m_pos[k] < R) begin
        an  = 2'b10;
        seg = dec(m_cur[k]);
      end else if (m_pos[k] >= R + b && m_pos[k] < 2 * R + b) begin
        an  = 2'b01;
        seg = dec(m_cur[k]);
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge
  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    model_out(0, e.an_a, e.seg_a);
    model_out(1, e.an_b, e.seg_b);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("sb_an_a", {5'd0, an_a}, {5'd0, e.an_a});
    chk("sb_seg_a", seg_a, e.seg_a);
    chk("sb_an_b", {5'd0, an_b}, {5'd0, e.an_b});
    chk("sb_seg_b", seg_b, e.seg_b);
  endtask

  typedef struct {
    logic [3:0] s0;
    logic [1:0] an_a;
    int         dig_a;
    logic [1:0] an_b;
    int         dig_b;
  } row_t;

  row_t tbl[26];

  task automatic add_row(input int c, input logic [3:0] v0, input logic [1:0] aa, input int da,
                         input logic [1:0] ab, input int db);
    tbl[c].s0    = v0;
    tbl[c].an_a  = aa;
    tbl[c].dig_a = da;
    tbl[c].an_b  = ab;
    tbl[c].dig_b = db;
  endtask

  // Row 0 is the cycle right after reset release; row c follows edge c-1
  task automatic run_table(input int upto);
    logic [6:0] sa, sb;
    for (int c = 0; c <= upto; c++) begin
      s0    = tbl[c].s0;
      s1    = 4'ha;
      en    = 1'b1;
      reset = 1'b0;
      if (c > 0) step();
      sa = (tbl[c].dig_a < 0) ? 7'h7f : dec(4'(tbl[c].dig_a));
      sb = (tbl[c].dig_b < 0) ? 7'h7f : dec(4'(tbl[c].dig_b));
      chk($sformatf("tbl_an_a[%0d]", c), {5'd0, an_a}, {5'd0, tbl[c].an_a});
      chk($sformatf("tbl_seg_a[%0d]", c), seg_a, sa);
      chk($sformatf("tbl_an_b[%0d]", c), {5'd0, an_b}, {5'd0, tbl[c].an_b});
      chk($sformatf("tbl_seg_b[%0d]", c), seg_b, sb);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b1;
    step();
    chk("reset_an_a", {5'd0, an_a}, 7'd3);
    chk("reset_seg_a", seg_a, 7'h7f);
    chk("reset_an_b", {5'd0, an_b}, 7'd3);
    chk("reset_seg_b", seg_b, 7'h7f);
  endtask

  initial begin
    //          c   s0     an_a  dig_a an_b  dig_b
    add_row( 0, 4'h3, 2'b11, -1, 2'b11, -1);
    add_row( 1, 4'h3, 2'b11, -1, 2'b10,  3);
    add_row( 2, 4'h3, 2'b10,  3, 2'b10,  3);
    add_row( 3, 4'h5, 2'b10,  3, 2'b10,  3);
    add_row( 4, 4'h5, 2'b10,  3, 2'b10,  3);
    add_row( 5, 4'h5, 2'b10,  3, 2'b01, 10);
    add_row( 6, 4'h5, 2'b11, -1, 2'b01, 10);
    add_row( 7, 4'h5, 2'b11, -1, 2'b01, 10);
    add_row( 8, 4'h5, 2'b01, 10, 2'b01, 10);
    add_row( 9, 4'h5, 2'b01, 10, 2'b10,  5);
    add_row(10, 4'h5, 2'b01, 10, 2'b10,  5);
    add_row(11, 4'h5, 2'b01, 10, 2'b10,  5);
    add_row(12, 4'h5, 2'b11, -1, 2'b10,  5);
    add_row(13, 4'h5, 2'b11, -1, 2'b01, 10);
    add_row(14, 4'h5, 2'b10,  5, 2'b01, 10);
    add_row(15, 4'h5, 2'b10,  5, 2'b01, 10);
    add_row(16, 4'h5, 2'b10,  5, 2'b01, 10);
    add_row(17, 4'h5, 2'b10,  5, 2'b10,  5);
    add_row(18, 4'h5, 2'b11, -1, 2'b10,  5);
    add_row(19, 4'h5, 2'b11, -1, 2'b10,  5);
    add_row(20, 4'h5, 2'b01, 10, 2'b10,  5);
    add_row(21, 4'h5, 2'b01, 10, 2'b01, 10);
    add_row(22, 4'h5, 2'b01, 10, 2'b01, 10);
    add_row(23, 4'h5, 2'b01, 10, 2'b01, 10);
    add_row(24, 4'h5, 2'b11, -1, 2'b01, 10);
    add_row(25, 4'h5, 2'b11, -1, 2'b10,  5);

    reset = 1'b1;
    en    = 1'b1;
    s0    = 4'h3;
    s1    = 4'ha;

    // Power-up sequence with s0 changed mid on-phase
    do_reset();
    do_reset();
    run_table(25);

    // Reset in the middle of digit 1, then the timeline must replay exactly
    do_reset();
    run_table(9);
    do_reset();
    run_table(25);

    // Enable dropped during digit 0 for five cycles
    do_reset();
    run_table(4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_low_an_a", {5'd0, an_a}, 7'd3);
      chk("en_low_seg_a", seg_a, 7'h7f);
      chk("en_low_an_b", {5'd0, an_b}, 7'd3);
    end
    en = 1'b1;
    s0 = 4'h7;
    step();
    chk("en_rise1_an_a", {5'd0, an_a}, 7'd3);
    chk("en_rise1_an_b", {5'd0, an_b}, 7'd2);
    chk("en_rise1_seg_b", seg_b, dec(4'h7));
    step();
    chk("en_rise2_an_a", {5'd0, an_a}, 7'd2);
    chk("en_rise2_seg_a", seg_a, dec(4'h7));

    // Random digits with occasional enable drops
    for (int i = 0; i < 1000; i++) begin
      s0 = 4'($urandom_range(0, 15));
      s1 = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 15) != 0);
      step();
      chk("overlap_a", {6'd0, an_a == 2'b00}, 7'd0);
      chk("overlap_b", {6'd0, an_b == 2'b00}, 7'd0);
      if (an_a == 2'b11) chk("dark_seg_a", seg_a, 7'h7f);
      if (an_b == 2'b11) chk("dark_seg_b", seg_b, 7'h7f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
